apb_master_bridge: RTL and testbench

- Converts the multicycle core's memory requests into APB transactions, then returns aligned and extended read data plus a completion pulse.
- Sits directly downstream of the core controller and datapath. It consumes the address, write data, direction, enable and access size (word/half/byte).
- Drives one APB slave port. Handles byte-lane steering, wait states, slave errors and a bus timeout.

---
 rtl/apb_pkg.sv | 27 ++
 rtl/apb_lane_align.sv | 45 ++++
 rtl/apb_master_bridge.sv | 160 ++++++++++++++++
 tb/tb_apb_master_bridge.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared states, access-size codes and helpers for the APB master bridge
package apb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    RESP   = 3'd3,
    ERR    = 3'd4
  } state_e;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam int         STRB_W  = 4;

  // Reserved size and naturally-misaligned half/word accesses never reach the bus.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_WORD: req_illegal = (addr_lo != 2'b00);
      SZ_HALF: req_illegal = addr_lo[0];
      SZ_BYTE: req_illegal = 1'b0;
      default: req_illegal = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/apb_lane_align.sv
// rtl/apb_lane_align.sv - byte-lane strobes, store replication and load extraction/extension
module apb_lane_align
  import apb_pkg::*;
(
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  input  logic [31:0]       wdata,
  input  logic [31:0]       prdata,
  input  logic              is_unsigned,
  output logic [STRB_W-1:0] strb,
  output logic [31:0]       wdata_steered,
  output logic [31:0]       rdata_ext
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted       = prdata >> {addr_lo, 3'b000};
    byte_sel      = shifted[7:0];
    half_sel      = addr_lo[1] ? prdata[31:16] : prdata[15:0];
    strb          = '0;
    wdata_steered = wdata;
    rdata_ext     = prdata;
    case (size)
      SZ_WORD: strb = 4'b1111;
      SZ_HALF: begin
        strb          = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_steered = {2{wdata[15:0]}};
        rdata_ext     = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      end
      SZ_BYTE: begin
        strb          = 4'b0001 << addr_lo;
        wdata_steered = {4{wdata[7:0]}};
        rdata_ext     = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      end
      default: begin
        wdata_steered = '0;
        rdata_ext     = '0;
      end
    endcase
  end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - core memory request to APB master with wait states, errors and timeout
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              req_done,
  output logic              req_err,
  output logic [31:0]       req_rdata,
  output logic              busy,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [31:0]       PWDATA,
  output logic [3:0]        PSTRB,
  input  logic [31:0]       PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  state_e              state_q, state_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic                write_q, write_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [31:0]         pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;

  logic [1:0]          al_size, al_addr;
  logic [STRB_W-1:0]   al_strb;
  logic [31:0]         al_wdata, al_rdata;
  logic                timeout_hit;

  // One aligner serves both paths: live request in IDLE, captured request afterwards.
  assign al_size = (state_q == IDLE) ? req_size      : size_q;
  assign al_addr = (state_q == IDLE) ? req_addr[1:0] : addr_lo_q;

  apb_lane_align u_align (
    .size          (al_size),
    .addr_lo       (al_addr),
    .wdata         (req_wdata),
    .prdata        (rdata_q),
    .is_unsigned   (unsigned_q),
    .strb          (al_strb),
    .wdata_steered (al_wdata),
    .rdata_ext     (al_rdata)
  );

  assign timeout_hit = (TIMEOUT_CYC != 0) && ((int'(cnt_q) + 1) >= TIMEOUT_CYC);

  always_comb begin
    state_d    = state_q;
    addr_lo_d  = addr_lo_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    write_d    = write_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    paddr_d    = paddr_q;
    pwrite_d   = pwrite_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_lo_d  = req_addr[1:0];
        size_d     = req_size;
        unsigned_d = req_unsigned;
        write_d    = req_write;
        rdata_d    = '0;
        err_d      = 1'b0;
        if (req_illegal(req_size, req_addr[1:0])) begin
          state_d = ERR;
        end else begin
          state_d  = SETUP;
          cnt_d    = '0;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pstrb_d  = req_write ? al_strb  : '0;
          pwdata_d = req_write ? al_wdata : '0;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY || timeout_hit) begin
          state_d  = RESP;
          rdata_d  = PRDATA;
          err_d    = PREADY ? PSLVERR : 1'b1;
          paddr_d  = '0;
          pwrite_d = 1'b0;
          pwdata_d = '0;
          pstrb_d  = '0;
        end
        if (!PREADY && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_lo_q  <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      write_q    <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_lo_q  <= addr_lo_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      write_q    <= write_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
    end
  end

  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = paddr_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign busy      = (state_q != IDLE);
  assign req_done  = (state_q == RESP) || (state_q == ERR);
  assign req_err   = (state_q == ERR) || ((state_q == RESP) && err_q);
  assign req_rdata = ((state_q == RESP) && !err_q && !write_q) ? al_rdata : '0;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - directed self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        req_done, req_err, busy;
  logic [31:0] req_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic        PREADY, PSLVERR;

  int checks = 0;
  int failures = 0;
  int cyc;
  int acc;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata), .busy(busy),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request in cycle 0; returns at the cycle-1 sampling point.
  task automatic start_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
    req_write = wr; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 1;
    while (req_done !== 1'b1 && c < 64) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_psel", PSEL, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", req_done, 0);
    chk("rst_paddr", PADDR, 0);
    reset = 1'b1;
    @(negedge clk);

    // Word store, zero wait
    start_req(1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 1'b0);
    chk("ws_psel_c1", PSEL, 1);
    chk("ws_pen_c1", PENABLE, 0);
    chk("ws_paddr", PADDR, 32'h100);
    chk("ws_pstrb", PSTRB, 4'b1111);
    chk("ws_pwdata", PWDATA, 32'hDEADBEEF);
    chk("ws_pwrite", PWRITE, 1);
    chk("ws_busy", busy, 1);
    @(negedge clk);
    chk("ws_pen_c2", PENABLE, 1);
    @(negedge clk);
    chk("ws_done_c3", req_done, 1);
    chk("ws_err", req_err, 0);
    chk("ws_rdata", req_rdata, 0);
    chk("ws_psel_c3", PSEL, 0);
    @(negedge clk);
    chk("ws_done_c4", req_done, 0);
    chk("ws_busy_c4", busy, 0);

    // Byte loads at 0x103, signed then unsigned
    PRDATA = 32'h80123456;
    start_req(1'b0, 32'h103, 32'hFFFFFFFF, 2'b10, 1'b0);
    chk("bl_pstrb", PSTRB, 0);
    chk("bl_pwdata", PWDATA, 0);
    wait_done(cyc);
    chk("bl_lat", cyc, 3);
    chk("bl_rdata_s", req_rdata, 32'hFFFFFF80);
    @(negedge clk);
    start_req(1'b0, 32'h103, 32'h0, 2'b10, 1'b1);
    chk("blu_pstrb", PSTRB, 0);
    wait_done(cyc);
    chk("blu_rdata", req_rdata, 32'h00000080);
    @(negedge clk);

    // Signed half load from upper lane
    PRDATA = 32'h80010000;
    start_req(1'b0, 32'h2, 32'h0, 2'b01, 1'b0);
    wait_done(cyc);
    chk("hl_rdata", req_rdata, 32'hFFFF8001);
    @(negedge clk);

    // Half store with 3 wait states
    PREADY = 1'b0;
    start_req(1'b1, 32'h202, 32'h0000ABCD, 2'b01, 1'b0);
    chk("hs_pstrb", PSTRB, 4'b1100);
    chk("hs_pwdata", PWDATA, 32'hABCDABCD);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hs_wait_pen", PENABLE, 1);
      chk("hs_wait_psel", PSEL, 1);
      chk("hs_wait_paddr", PADDR, 32'h202);
      chk("hs_wait_done", req_done, 0);
    end
    @(negedge clk);
    PREADY = 1'b1;
    chk("hs_last_pen", PENABLE, 1);
    @(negedge clk);
    chk("hs_done_c6", req_done, 1);
    chk("hs_err", req_err, 0);
    @(negedge clk);

    // Misaligned half load and reserved size
    start_req(1'b0, 32'h101, 32'h0, 2'b01, 1'b0);
    chk("mis_done_c1", req_done, 1);
    chk("mis_err", req_err, 1);
    chk("mis_psel", PSEL, 0);
    chk("mis_rdata", req_rdata, 0);
    @(negedge clk);
    chk("mis_busy_c2", busy, 0);
    chk("mis_psel_c2", PSEL, 0);
    start_req(1'b0, 32'h0, 32'h0, 2'b11, 1'b0);
    chk("rsv_done_c1", req_done, 1);
    chk("rsv_err", req_err, 1);
    chk("rsv_psel", PSEL, 0);
    @(negedge clk);

    // Timeout with PREADY stuck low
    PREADY = 1'b0;
    PRDATA = 32'h5A5A5A5A;
    start_req(1'b0, 32'h40, 32'h0, 2'b00, 1'b0);
    acc = 0;
    cyc = 1;
    while (req_done !== 1'b1 && cyc < 64) begin
      if (PENABLE === 1'b1) acc++;
      @(negedge clk);
      cyc++;
    end
    chk("to_access_cycles", acc, 16);
    chk("to_lat", cyc, 18);
    chk("to_err", req_err, 1);
    chk("to_rdata", req_rdata, 0);
    chk("to_psel", PSEL, 0);
    PREADY = 1'b1;
    @(negedge clk);

    // Slave error
    PSLVERR = 1'b1;
    start_req(1'b0, 32'h80, 32'h0, 2'b00, 1'b0);
    wait_done(cyc);
    chk("se_lat", cyc, 3);
    chk("se_err", req_err, 1);
    chk("se_rdata", req_rdata, 0);
    PSLVERR = 1'b0;
    @(negedge clk);

    // Reset mid-ACCESS, then a clean word load
    PREADY = 1'b0;
    start_req(1'b1, 32'h300, 32'h11223344, 2'b00, 1'b0);
    @(negedge clk);
    chk("mr_pen_before", PENABLE, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mr_psel", PSEL, 0);
    chk("mr_pen", PENABLE, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", req_done, 0);
    chk("mr_paddr", PADDR, 0);
    reset = 1'b1;
    PREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mr_no_done", req_done, 0);
    end
    PRDATA = 32'h12345678;
    start_req(1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
    wait_done(cyc);
    chk("pr_lat", cyc, 3);
    chk("pr_err", req_err, 0);
    chk("pr_rdata", req_rdata, 32'h12345678);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
